// File: rtl/line_stream_drawer.sv
// line_stream_drawer: streams the pixels of a straight line from (x0,y0)
// to (x1,y1) using the all-octant Bresenham step, one pixel per accepted
// transfer on a valid/ready output port.
//
// Output handshake: pix_valid is high for the whole DRAW state. While
// pix_valid is high and pix_ready is low, pix_x/pix_y/pix_color/pix_last
// hold their values. A pixel is delivered on a rising edge where
// pix_valid && pix_ready. pix_valid never depends on pix_ready.
module line_stream_drawer #(
  parameter int COORD_W = 11,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] color,
  input  logic               abort,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_last,
  output logic               done,
  output logic [1:0]         state_dbg
);

  // Error term is two bits wider than a coordinate so that 2*err and the
  // combined dx/dy updates never overflow over the full coordinate range.
  localparam int EW = COORD_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [COLOR_W-1:0] color_q;

  // Bresenham working registers
  logic [COORD_W-1:0] dx_q, dy_q;
  logic               sx_neg, sy_neg;
  logic signed [EW-1:0] err_q;
  logic [COORD_W-1:0] cur_x, cur_y;

  // Combinational helpers
  logic [COORD_W-1:0]   abs_dx, abs_dy;
  logic signed [EW-1:0] dx_s, dy_s;
  logic signed [EW-1:0] e2;
  logic signed [EW-1:0] err_nxt;
  logic                 step_x, step_y;
  logic                 at_end;
  logic                 xfer;

  // Absolute deltas of the latched endpoints, used once in SETUP.
  always_comb begin
    abs_dx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    abs_dy = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
  end

  // Bresenham step decision for the current point and the resulting error.
  always_comb begin
    dx_s    = $signed({2'b00, dx_q});
    dy_s    = $signed({2'b00, dy_q});
    e2      = err_q <<< 1;
    step_x  = (e2 >= -dy_s);
    step_y  = (e2 <= dx_s);
    err_nxt = err_q;
    if (step_x) err_nxt = err_nxt - dy_s;
    if (step_y) err_nxt = err_nxt + dx_s;
  end

  assign at_end = (cur_x == x1_q) && (cur_y == y1_q);
  assign xfer   = (state == DRAW) && pix_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort wins over a coincident transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = abort ? IDLE : DRAW;
      DRAW: begin
        if (abort)                state_nxt = IDLE;
        else if (xfer && at_end)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, SETUP initialisation and per-transfer stepping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
      err_q   <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            color_q <= color;
          end
        end
        SETUP: begin
          dx_q   <= abs_dx;
          dy_q   <= abs_dy;
          sx_neg <= (x1_q < x0_q);
          sy_neg <= (y1_q < y0_q);
          err_q  <= $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
          cur_x  <= x0_q;
          cur_y  <= y0_q;
        end
        DRAW: begin
          // The endpoint is never stepped past, so no coordinate wraps.
          if (xfer && !at_end) begin
            err_q <= err_nxt;
            if (step_x) cur_x <= sx_neg ? (cur_x - COORD_W'(1)) : (cur_x + COORD_W'(1));
            if (step_y) cur_y <= sy_neg ? (cur_y - COORD_W'(1)) : (cur_y + COORD_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state and the working registers.
  assign busy      = (state != IDLE);
  assign pix_valid = (state == DRAW);
  assign pix_x     = cur_x;
  assign pix_y     = cur_y;
  assign pix_color = color_q;
  assign pix_last  = (state == DRAW) && at_end;
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_line_stream_drawer.sv
// Directed bench for line_stream_drawer: expected pixels are queued before
// each line is started and popped as the DUT delivers them.
module tb_line_stream_drawer;

  localparam int CW = 11;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [KW-1:0] color = '0;
  logic          abort = 1'b0;
  logic          pix_ready = 1'b0;
  logic          busy, pix_valid, pix_last, done;
  logic [CW-1:0] pix_x, pix_y;
  logic [KW-1:0] pix_color;
  logic [1:0]    state_dbg;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [2*CW:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  line_stream_drawer #(.COORD_W(CW), .COLOR_W(KW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .abort(abort),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_last(pix_last), .done(done), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*CW:0] pk(input int x, input int y, input bit l);
    return {CW'(x), CW'(y), l};
  endfunction

  // Reference line generator (integer arithmetic, no width limits).
  task automatic push_model(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    sx = (ax1 >= ax0) ? 1 : -1;
    sy = (ay1 >= ay0) ? 1 : -1;
    err = dx - dy;
    x = ax0;
    y = ay0;
    while (1) begin
      exp_q.push_back(pk(x, y, (x == ax1) && (y == ay1)));
      if ((x == ax1) && (y == ay1)) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err = err - dy; x = x + sx; end
      if (e2 <= dx)  begin err = err + dx; y = y + sy; end
    end
  endtask

  // Driver + checker for one line. rmode 0: ready always high;
  // rmode 1: ready pattern 1,0,0 repeating. abort_at: pixel index whose
  // transfer coincides with abort (-1 = none). noisy: hold start high with
  // other coordinates while the line is drawing.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int acol, input int rmode, input int abort_at, input bit noisy);
    int n_exp, got, cyc;
    bit held, finished, aborted;
    logic [CW-1:0] hx, hy;
    logic [KW-1:0] hc;
    logic hl;
    logic [2*CW:0] e;
    n_exp = exp_q.size();
    got = 0; cyc = 0; held = 0; finished = 0; aborted = 0;
    hx = '0; hy = '0; hc = '0; hl = 1'b0;
    @(negedge clk);
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    color = KW'(acol); start = 1'b1; pix_ready = 1'b0;
    @(posedge clk); #1;
    if (noisy) begin
      x0 = CW'(123); y0 = CW'(45); x1 = CW'(6); y1 = CW'(789); color = 8'h5a;
    end else start = 1'b0;
    @(negedge clk);
    chk("setup_busy", 32'(busy), 32'(1));
    chk("setup_valid", 32'(pix_valid), 32'(0));
    while (!finished && cyc < 6000) begin
      @(negedge clk);
      pix_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (rmode == 0 || held) chk("valid_high", 32'(pix_valid), 32'(1));
      if (held) begin
        chk("hold_x", 32'(pix_x), 32'(hx));
        chk("hold_y", 32'(pix_y), 32'(hy));
        chk("hold_color", 32'(pix_color), 32'(hc));
        chk("hold_last", 32'(pix_last), 32'(hl));
      end
      if (pix_valid && pix_ready) begin
        held = 0;
        if (exp_q.size() == 0) begin
          chk("pix_count_excess", 32'(got + 1), 32'(n_exp));
          finished = 1;
        end else begin
          e = exp_q.pop_front();
          chk("pix_xy_last", 32'({pix_x, pix_y, pix_last}), 32'(e));
          chk("pix_color", 32'(pix_color), 32'(acol));
          got++;
          if (got - 1 == abort_at) begin
            abort = 1'b1; aborted = 1; finished = 1;
          end else if (pix_last) begin
            finished = 1;
            start = 1'b0;
          end
        end
      end else if (pix_valid) begin
        held = 1; hx = pix_x; hy = pix_y; hc = pix_color; hl = pix_last;
      end else held = 0;
      cyc++;
    end
    chk("line_in_budget", 32'(finished), 32'(1));
    if (aborted) begin
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("abort_valid", 32'(pix_valid), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'(0));
      end
      chk("abort_pixels", 32'(got), 32'(abort_at + 1));
      exp_q.delete();
    end else begin
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'(1));
      chk("done_valid", 32'(pix_valid), 32'(0));
      chk("pix_count", 32'(got), 32'(n_exp));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("done_once", 32'(done), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
    end
    start = 1'b0;
    pix_ready = 1'b0;
  endtask

  initial begin
    // Reset block
    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(pix_valid), 32'(0));
    chk("rst_x", 32'(pix_x), 32'(0));
    chk("rst_y", 32'(pix_y), 32'(0));
    chk("rst_color", 32'(pix_color), 32'(0));
    chk("rst_last", 32'(pix_last), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_state", 32'(state_dbg), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Horizontal line, ready held high
    for (int i = 0; i <= 4; i++) exp_q.push_back(pk(i, 0, i == 4));
    run_line(0, 0, 4, 0, 8'h11, 0, -1, 1'b0);

    // Steep line, start held high with other values while drawing
    exp_q.push_back(pk(0, 0, 0));
    exp_q.push_back(pk(0, 1, 0));
    exp_q.push_back(pk(1, 2, 0));
    exp_q.push_back(pk(1, 3, 1));
    run_line(0, 0, 1, 3, 8'h22, 0, -1, 1'b1);

    // Diagonal up-left with back-pressure
    for (int i = 0; i < 4; i++) exp_q.push_back(pk(5 - i, 5 - i, i == 3));
    run_line(5, 5, 2, 2, 8'h33, 1, -1, 1'b0);

    // Degenerate single-pixel line
    exp_q.push_back(pk(7, 9, 1));
    run_line(7, 9, 7, 9, 8'h44, 0, -1, 1'b0);

    // Full-range descending line
    for (int i = 0; i < 2048; i++) exp_q.push_back(pk(2047 - i, 0, i == 2047));
    run_line(2047, 0, 0, 0, 8'h55, 0, -1, 1'b0);

    // Other octants, full-range diagonal
    push_model(10, 10, 3, 14);
    run_line(10, 10, 3, 14, 8'h66, 1, -1, 1'b0);
    push_model(3, 14, 10, 2);
    run_line(3, 14, 10, 2, 8'h67, 0, -1, 1'b0);
    push_model(0, 2047, 2047, 0);
    run_line(0, 2047, 2047, 0, 8'h68, 0, -1, 1'b0);

    // Random short lines
    repeat (4) begin
      int rx0, ry0, rx1, ry1, rm;
      rx0 = int'($urandom_range(0, 30)); ry0 = int'($urandom_range(0, 30));
      rx1 = int'($urandom_range(0, 30)); ry1 = int'($urandom_range(0, 30));
      rm  = int'($urandom_range(0, 1));
      push_model(rx0, ry0, rx1, ry1);
      run_line(rx0, ry0, rx1, ry1, int'($urandom_range(0, 255)), rm, -1, 1'b0);
    end

    // Abort coincident with the third pixel transfer
    for (int i = 0; i < 3; i++) exp_q.push_back(pk(i, 0, 0));
    run_line(0, 0, 10, 0, 8'h77, 0, 2, 1'b0);

    // Asynchronous reset in the middle of a line
    @(negedge clk);
    x0 = '0; y0 = '0; x1 = CW'(10); y1 = '0; color = 8'h88;
    start = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", 32'(pix_valid), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(pix_valid), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_x", 32'(pix_x), 32'(0));
    chk("async_rst_done", 32'(done), 32'(0));
    chk("async_rst_state", 32'(state_dbg), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 32'(0));
      chk("post_rst_valid", 32'(pix_valid), 32'(0));
    end
    pix_ready = 1'b0;

    // Fresh line after reset
    push_model(3, 1, 6, 3);
    run_line(3, 1, 6, 3, 8'h99, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/line_stream_drawer.md
LINE_STREAM_DRAWER -- requirements
Module: line_stream_drawer

Interface
REQ-001 Parameter: COORD_W, default 11, width of every coordinate port (unsigned).
REQ-002 Parameter: COLOR_W, default 8, width of the colour tag carried with each pixel.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to draw a line; sampled only in IDLE.
REQ-006 x0, y0, x1, y1  input  COORD_W each  endpoint coordinates; sampled with start.
REQ-007 color  input  COLOR_W  colour tag; sampled with start.
REQ-008 abort  input  1  cancel the line in progress.
REQ-009 busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-010 pix_valid  output  1  pix_x/pix_y/pix_color/pix_last hold a valid pixel.
REQ-011 pix_ready  input  1  consumer accepts the pixel; transfer = pix_valid && pix_ready at a rising edge.
REQ-012 pix_x, pix_y  output  COORD_W each  pixel coordinate.
REQ-013 pix_color  output  COLOR_W  latched colour tag.
REQ-014 pix_last  output  1  current pixel is endpoint (x1,y1).
REQ-015 done  output  1  one-cycle pulse after the last pixel transfers.

Function
REQ-016 States SHALL be IDLE, SETUP, DRAW, DONE.
REQ-017 IDLE: start=1 SHALL latch x0,y0,x1,y1,color and move to SETUP; start outside IDLE SHALL be ignored.
REQ-018 SETUP (one cycle): dx=|x1-x0|, dy=|y1-y0|, sx=+1 if x1>=x0 else -1, sy=+1 if y1>=y0 else -1, err=dx-dy, current point=(x0,y0); then DRAW.
REQ-019 Arithmetic: dx, dy unsigned COORD_W; err and 2*err signed COORD_W+2 bits; no overflow for any input pair in full coordinate range.
REQ-020 All eight octants SHALL be handled without coordinate swapping, using the all-octant Bresenham step.
REQ-021 Step on each transfer: e2=2*err; if e2 >= -dy then err-=dy, x+=sx; if e2 <= dx then err+=dx, y+=sy (both may apply; err updates combine).
REQ-022 DRAW: pix_valid=1 and outputs show current point; pix_last=1 when current point equals (x1,y1).
REQ-023 With pix_ready=0, pix_x, pix_y, pix_color, pix_last SHALL hold stable and pix_valid stay high.
REQ-024 Pixel sequence SHALL contain exactly max(dx,dy)+1 pixels, first (x0,y0), last (x1,y1), no duplicates.
REQ-025 Transfer of the pix_last pixel SHALL move to DONE; pix_valid=0 in DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE.
REQ-027 Latency: start accepted at edge N -> SETUP in cycle N+1, first pix_valid in cycle N+2; with pix_ready held high, one pixel per cycle.
REQ-028 Degenerate line (x0=x1, y0=y1): single pixel with pix_last=1, then DONE.
REQ-029 abort=1 in SETUP or DRAW SHALL go to IDLE at the next edge; no done pulse; pix_valid=0 from next cycle.
REQ-030 abort coincident with a transfer: that pixel counts as delivered; abort still wins, no further pixels.
REQ-031 abort in IDLE or DONE SHALL be ignored; DONE pulse completes.

Reset
REQ-032 reset_n=0 SHALL force IDLE immediately, without waiting for clk.
REQ-033 Reset values: busy=0, pix_valid=0, pix_x=0, pix_y=0, pix_color=0, pix_last=0, done=0; internal registers 0.
REQ-034 Reset mid-line SHALL drop the line; no done pulse; after release, block accepts a fresh start.

Verification
REQ-035 (0,0)->(4,0), ready=1: pixels x=0..4 at y=0 on consecutive cycles, first 2 cycles after start edge, pix_last with (4,0), done one cycle after.
REQ-036 (0,0)->(1,3): exactly (0,0),(0,1),(1,2),(1,3); pix_last on (1,3).
REQ-037 (5,5)->(2,2) with pix_ready toggling 1,0,0,1,...: (5,5),(4,4),(3,3),(2,2), outputs stable while ready=0, count 4.
REQ-038 (7,9)->(7,9): one pixel (7,9) with pix_last=1, then done pulse.
REQ-039 (2047,0)->(0,0): 2048 pixels, x descending 2047..0, y=0, no wrap; pix_last on (0,0).
REQ-040 abort on 3rd pixel of (0,0)->(10,0), then reset_n pulse mid-line of a second start: no done either time, pix_valid=0 next cycle / immediately, new start draws correctly.
